// File: rtl/dw_pipe_pkg.sv
// dw_pipe_pkg: shared constants and helpers for the dw_pipe_ctrl valid/ready sequencer
package dw_pipe_pkg;
  localparam int DEPTH_MAX = 64;
  localparam logic [DEPTH_MAX-1:0] VLD_RST = '0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dw_pipe_ctrl_if.sv
// dw_pipe_ctrl_if: handshake and stage-control bundle; occ exists only with DW_PIPE_CTRL_OCC_EN
interface dw_pipe_ctrl_if
  import dw_pipe_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic in_valid, in_ready, out_valid, out_ready, flush;
  logic [DEPTH-1:0] stage_en, stage_vld;
`ifdef DW_PIPE_CTRL_OCC_EN
  logic [clog2(DEPTH+1)-1:0] occ;
`endif
  modport master (
    output in_valid, out_ready, flush,
    input in_ready, out_valid, stage_en, stage_vld
`ifdef DW_PIPE_CTRL_OCC_EN
    , occ
`endif
  );
  modport slave (
    input in_valid, out_ready, flush,
    output in_ready, out_valid, stage_en, stage_vld
`ifdef DW_PIPE_CTRL_OCC_EN
    , occ
`endif
  );
endinterface

// File: rtl/dw_pipe_stage_ctrl.sv
// dw_pipe_stage_ctrl: one stage's valid flop plus its ready and load-enable logic
module dw_pipe_stage_ctrl
  import dw_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic nxt_rdy_i,
  input  logic flush_i,
  output logic vld_o,
  output logic rdy_o,
  output logic en_o
);
  logic v_q, v_d;
  always_comb begin
    rdy_o = ~v_q | nxt_rdy_i;
    en_o  = rdy_o & src_i & ~flush_i & rst_n;
    v_d   = flush_i ? 1'b0 : rdy_o ? src_i : v_q;
  end
  always_ff @(posedge clk) v_q <= !rst_n ? VLD_RST[0] : v_d;
  assign vld_o = v_q;
endmodule

// File: rtl/dw_pipe_ctrl.sv
// dw_pipe_ctrl: valid/ready sequencer driving per-stage load enables of an external DEPTH-stage pipe
// Define DW_PIPE_CTRL_OCC_EN to add the registered occupancy counter output occ.
module dw_pipe_ctrl
  import dw_pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OCC_W = 3
) (
  input logic          clk,
  input logic          rst_n,
  dw_pipe_ctrl_if.slave bus
);
  logic [DEPTH-1:0] vld, en;
  if (DEPTH < 1 || DEPTH > DEPTH_MAX || OCC_W < clog2(DEPTH + 1)) begin : g_bad_cfg
    $error("dw_pipe_ctrl: DEPTH or OCC_W out of range");
  end
  // each stage's ready looks one stage ahead, ending at the consumer
  for (genvar i = 0; i < DEPTH; i++) begin : g
    logic r, n, s;
    if (i == DEPTH - 1) begin : l
      assign n = bus.out_ready;
    end else begin : m
      assign n = g[i+1].r;
    end
    if (i == 0) begin : f
      assign s = bus.in_valid;
    end else begin : p
      assign s = vld[i-1];
    end
    dw_pipe_stage_ctrl u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .src_i    (s),
      .nxt_rdy_i(n),
      .flush_i  (bus.flush),
      .vld_o    (vld[i]),
      .rdy_o    (r),
      .en_o     (en[i])
    );
  end
  assign bus.in_ready  = g[0].r & ~bus.flush & rst_n;
  assign bus.out_valid = vld[DEPTH-1];
  assign bus.stage_vld = vld;
  assign bus.stage_en  = en;
`ifdef DW_PIPE_CTRL_OCC_EN
  logic [OCC_W-1:0] occ_q, occ_d;
  always_comb occ_d = bus.flush ? '0
    : occ_q + OCC_W'(bus.in_valid & bus.in_ready) - OCC_W'(bus.out_valid & bus.out_ready);
  always_ff @(posedge clk) occ_q <= !rst_n ? '0 : occ_d;
  assign bus.occ = $bits(bus.occ)'(occ_q);
  a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_W'(DEPTH));
`endif
endmodule

// File: tb/tb_dw_pipe_ctrl.sv
// tb_dw_pipe_ctrl: scoreboard bench with a model datapath for DEPTH=4 and DEPTH=1 controllers
module tb_dw_pipe_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] din_a, din_b, db;
  logic [7:0] da [4];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  int pass_cnt = 0, tot_cnt = 0, pops_a = 0, pops_b = 0, p0;
  logic vm;
  logic exp_rdy;
  logic [3:0] bexp [3];
  always #5 clk = ~clk;
  dw_pipe_ctrl_if #(.DEPTH(4)) a ();
  dw_pipe_ctrl_if #(.DEPTH(1)) b ();
  dw_pipe_ctrl #(.DEPTH(4), .OCC_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  dw_pipe_ctrl #(.DEPTH(1), .OCC_W(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  // datapath registers the integrator would build, loaded only by stage_en
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (a.stage_en[i]) da[i] <= (i == 0) ? din_a : da[i-1];
    if (b.stage_en[0]) db <= din_b;
  end
  always @(negedge clk) begin
    if (a.out_valid && a.out_ready) begin
      if (qa.size() == 0) chk("a_pop_unexpected", 32'(a.out_valid), 32'd0);
      else chk("a_data", 32'(da[3]), 32'(qa.pop_front()));
      pops_a++;
    end
    if (a.flush || !rst_n) qa.delete();
    else if (a.in_valid && a.in_ready) qa.push_back(din_a);
    if (b.out_valid && b.out_ready) begin
      if (qb.size() == 0) chk("b_pop_unexpected", 32'(b.out_valid), 32'd0);
      else chk("b_data", 32'(db), 32'(qb.pop_front()));
      pops_b++;
    end
    if (b.flush || !rst_n) qb.delete();
    else if (b.in_valid && b.in_ready) qb.push_back(din_b);
  end
  initial begin
    rst_n = 1'b0;
    a.in_valid = 1'b1; a.out_ready = 1'b0; a.flush = 1'b0; din_a = 8'hAA;
    b.in_valid = 1'b0; b.out_ready = 1'b0; b.flush = 1'b0; din_b = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(a.out_valid), 32'd0);
      chk("rst_stage_en", 32'(a.stage_en), 32'd0);
      chk("rst_in_ready", 32'(a.in_ready), 32'd0);
      nxt();
    end
    rst_n = 1'b1; a.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(a.in_ready), 32'd1);
    chk("post_rst_stage_vld", 32'(a.stage_vld), 32'd0);
`ifdef DW_PIPE_CTRL_OCC_EN
    chk("post_rst_occ", 32'(a.occ), 32'd0);
`endif
    nxt();
    a.out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      a.in_valid = (k < 8);
      din_a = 8'(8'h11 + k);
      @(negedge clk);
      chk("stream_out_valid", 32'(a.out_valid), 32'(k >= 4 && k < 12));
      nxt();
    end
    chk("stream_count", 32'(pops_a), 32'd8);
    a.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a.in_valid = 1'b1;
      din_a = 8'(8'h21 + k);
      @(negedge clk);
      chk("fill_stage_vld", 32'(a.stage_vld), 32'((1 << k) - 1));
      chk("fill_stage_en", 32'(a.stage_en), 32'((2 << k) - 1));
      nxt();
    end
    din_a = 8'h25;
    repeat (2) begin
      @(negedge clk);
      chk("full_in_ready", 32'(a.in_ready), 32'd0);
      chk("full_stage_vld", 32'(a.stage_vld), 32'hF);
      chk("full_stage_en", 32'(a.stage_en), 32'd0);
      chk("full_out_valid", 32'(a.out_valid), 32'd1);
`ifdef DW_PIPE_CTRL_OCC_EN
      chk("full_occ", 32'(a.occ), 32'd4);
`endif
      nxt();
    end
    a.out_ready = 1'b1;
    @(negedge clk);
    p0 = pops_a;
    chk("bp_in_ready", 32'(a.in_ready), 32'd1);
    chk("bp_stage_en", 32'(a.stage_en), 32'hF);
    nxt();
    a.out_ready = 1'b0; a.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_one_output", 32'(pops_a - p0), 32'd1);
    chk("bp_still_full", 32'(a.stage_vld), 32'hF);
    chk("bp_in_ready_low", 32'(a.in_ready), 32'd0);
    nxt();
    a.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      nxt();
    end
    a.out_ready = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", 32'(a.out_valid), 32'd0);
    chk("drain_count", 32'(pops_a), 32'd13);
    nxt();
    a.in_valid = 1'b1; din_a = 8'h31;
    @(negedge clk);
    nxt();
    a.in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      nxt();
    end
    bexp[0] = 4'h8; bexp[1] = 4'h9; bexp[2] = 4'hB;
    a.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din_a = 8'(8'h32 + k);
      @(negedge clk);
      chk("bubble_stage_vld", 32'(a.stage_vld), 32'(bexp[k]));
      chk("bubble_no_en3", 32'(a.stage_en[3]), 32'd0);
      nxt();
    end
    a.in_valid = 1'b0;
    @(negedge clk);
    chk("bubble_full", 32'(a.stage_vld), 32'hF);
    nxt();
    a.flush = 1'b1; a.in_valid = 1'b1; a.out_ready = 1'b1; din_a = 8'h99;
    @(negedge clk);
    chk("flush_in_ready", 32'(a.in_ready), 32'd0);
    chk("flush_stage_en", 32'(a.stage_en), 32'd0);
    nxt();
    a.flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b0;
    @(negedge clk);
    chk("flush_stage_vld", 32'(a.stage_vld), 32'd0);
    chk("flush_out_valid", 32'(a.out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(a.in_ready), 32'd1);
`ifdef DW_PIPE_CTRL_OCC_EN
    chk("flush_occ", 32'(a.occ), 32'd0);
`endif
    nxt();
    a.in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din_a = 8'(8'h51 + k);
      @(negedge clk);
      nxt();
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stage_en", 32'(a.stage_en), 32'd0);
    chk("midrst_in_ready", 32'(a.in_ready), 32'd0);
    nxt();
    rst_n = 1'b1; a.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_stage_vld", 32'(a.stage_vld), 32'd0);
    chk("midrst_out_valid", 32'(a.out_valid), 32'd0);
    chk("a_queue_left", 32'(qa.size()), 32'd0);
    nxt();
    vm = 1'b0;
    b.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b.out_ready = (k % 2 == 0);
      din_b = 8'(8'h41 + k);
      exp_rdy = ~vm | b.out_ready;
      @(negedge clk);
      chk("d1_in_ready", 32'(b.in_ready), 32'(exp_rdy));
      chk("d1_out_valid", 32'(b.out_valid), 32'(vm));
      if (exp_rdy) vm = 1'b1;
      nxt();
    end
    b.in_valid = 1'b0; b.out_ready = 1'b1;
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk("d1_pop_count", 32'(pops_b), 32'd5);
    chk("d1_queue_left", 32'(qb.size()), 32'd0);
    chk("d1_out_valid_end", 32'(b.out_valid), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
